cordic_pre_pipe: RTL and testbench

// Parametrised front end of the vectoring CORDIC: folds (X,Y) into the first octant and emits |X|>=|Y|>=0 plus a 3-bit octant code.
// The back end uses that code to restore the angle.
// Two-stage valid pipeline with global stall (ena), saturation of the most-negative input, zero-vector flag and sideband tag.

---
 rtl/cordic_pkg.sv | 11 +
 rtl/cordic_abs_sat.sv | 33 +++
 rtl/cordic_pre_pipe.sv | 118 +++++++++++
 tb/tb_cordic_pre_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Definitions shared by the CORDIC vectoring front end and its angle-restoring post-stage.
package cordic_pkg;

  // Bit positions inside the 3-bit octant code {yneg, xneg, swap}
  localparam int Q_YNEG = 2;
  localparam int Q_XNEG = 1;
  localparam int Q_SWAP = 0;

  typedef logic [2:0] octant_t;

endpackage

// File: rtl/cordic_abs_sat.sv
// Combinational magnitude and sign of a two's-complement word.
// With SAT=1 the most-negative code clamps to the largest positive value.
module cordic_abs_sat #(
  parameter int W   = 16,
  parameter int SAT = 1
) (
  input  logic signed [W-1:0] d,
  output logic        [W-1:0] mag,
  output logic                neg
);

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] w_raw;
  logic [W-1:0] w_neg_mag;

  assign w_raw     = d;
  assign w_neg_mag = (~w_raw) + ONE;
  assign neg       = w_raw[W-1];

  // Negating -2^(W-1) wraps back to 2^(W-1), which is the correct unsigned result when SAT=0
  always_comb begin
    mag = w_raw;
    if (w_raw == MIN_NEG) begin
      mag = (SAT != 0) ? MAX_POS : MIN_NEG;
    end else if (w_raw[W-1]) begin
      mag = w_neg_mag;
    end
  end

endmodule

// File: rtl/cordic_pre_pipe.sv
// Vectoring CORDIC front end: folds (X,Y) into the first octant over two
// register stages with global stall, zero-vector flag and sideband tag.
module cordic_pre_pipe
  import cordic_pkg::*;
#(
  parameter int W     = 16,
  parameter int TAG_W = 4,
  parameter int SAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 valid_i,
  input  logic signed [W-1:0]  xi,
  input  logic signed [W-1:0]  yi,
  input  logic [TAG_W-1:0]     tag_i,
  output logic                 valid_o,
  output logic [W-1:0]         xo,
  output logic [W-1:0]         yo,
  output logic [2:0]           q,
  output logic                 zero,
  output logic [TAG_W-1:0]     tag_o
);

  logic [W-1:0]     w_mx;
  logic [W-1:0]     w_my;
  logic             w_xneg;
  logic             w_yneg;
  logic             w_zero;
  logic             w_swap;
  octant_t          w_q;

  logic [W-1:0]     r_mx;
  logic [W-1:0]     r_my;
  logic             r_xneg;
  logic             r_yneg;
  logic             r_zero1;
  logic [TAG_W-1:0] r_tag1;
  logic             r_v1;

  logic [W-1:0]     r_xo;
  logic [W-1:0]     r_yo;
  octant_t          r_q;
  logic             r_zero2;
  logic [TAG_W-1:0] r_tag2;
  logic             r_v2;

  cordic_abs_sat #(.W(W), .SAT(SAT)) u_abs_x (
    .d   (xi),
    .mag (w_mx),
    .neg (w_xneg)
  );

  cordic_abs_sat #(.W(W), .SAT(SAT)) u_abs_y (
    .d   (yi),
    .mag (w_my),
    .neg (w_yneg)
  );

  assign w_zero = (xi == '0) && (yi == '0);

  // Equal magnitudes stay unswapped so the back end never sees an ambiguous fold
  assign w_swap = (r_my > r_mx);

  always_comb begin
    w_q         = '0;
    w_q[Q_YNEG] = r_yneg;
    w_q[Q_XNEG] = r_xneg;
    w_q[Q_SWAP] = w_swap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mx    <= '0;
      r_my    <= '0;
      r_xneg  <= 1'b0;
      r_yneg  <= 1'b0;
      r_zero1 <= 1'b0;
      r_tag1  <= '0;
      r_v1    <= 1'b0;
    end else if (ena) begin
      r_mx    <= w_mx;
      r_my    <= w_my;
      r_xneg  <= w_xneg;
      r_yneg  <= w_yneg;
      r_zero1 <= w_zero;
      r_tag1  <= tag_i;
      r_v1    <= valid_i;
    end
  end

  // Every stage-2 field comes from the same stage-1 sample, so sideband never skews
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xo    <= '0;
      r_yo    <= '0;
      r_q     <= '0;
      r_zero2 <= 1'b0;
      r_tag2  <= '0;
      r_v2    <= 1'b0;
    end else if (ena) begin
      r_xo    <= w_swap ? r_my : r_mx;
      r_yo    <= w_swap ? r_mx : r_my;
      r_q     <= w_q;
      r_zero2 <= r_zero1;
      r_tag2  <= r_tag1;
      r_v2    <= r_v1;
    end
  end

  assign valid_o = r_v2;
  assign xo      = r_xo;
  assign yo      = r_yo;
  assign q       = r_q;
  assign zero    = r_zero2;
  assign tag_o   = r_tag2;

endmodule

// File: tb/tb_cordic_pre_pipe.sv
// Self-checking bench for cordic_pre_pipe: directed table, stall/reset sequences
// and a randomized sweep against an arithmetic reference model.
module tb_cordic_pre_pipe;

  localparam int W     = 16;
  localparam int TAG_W = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                ena = 1'b0;
  logic                valid_i = 1'b0;
  logic signed [W-1:0] xi = '0;
  logic signed [W-1:0] yi = '0;
  logic [TAG_W-1:0]    tag_i = '0;

  logic                valid_o;
  logic [W-1:0]        xo;
  logic [W-1:0]        yo;
  logic [2:0]          q;
  logic                zero;
  logic [TAG_W-1:0]    tag_o;

  logic                valid_o_u;
  logic [W-1:0]        xo_u;
  logic [W-1:0]        yo_u;
  logic [2:0]          q_u;
  logic                zero_u;
  logic [TAG_W-1:0]    tag_o_u;

  always #5 clk = ~clk;

  cordic_pre_pipe #(.W(W), .TAG_W(TAG_W), .SAT(1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .valid_i(valid_i),
    .xi(xi), .yi(yi), .tag_i(tag_i),
    .valid_o(valid_o), .xo(xo), .yo(yo), .q(q), .zero(zero), .tag_o(tag_o)
  );

  cordic_pre_pipe #(.W(W), .TAG_W(TAG_W), .SAT(0)) dut_nosat (
    .clk(clk), .rst(rst), .ena(ena), .valid_i(valid_i),
    .xi(xi), .yi(yi), .tag_i(tag_i),
    .valid_o(valid_o_u), .xo(xo_u), .yo(yo_u), .q(q_u), .zero(zero_u), .tag_o(tag_o_u)
  );

  typedef struct {
    logic                v;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic [TAG_W-1:0]    tag;
  } smp_t;

  typedef struct {
    logic             v;
    logic [W-1:0]     xo;
    logic [W-1:0]     yo;
    logic [2:0]       q;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic [TAG_W-1:0]    tag;
    logic [W-1:0]        xo;
    logic [W-1:0]        yo;
    logic [2:0]          q;
    logic                zero;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  smp_t hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: magnitudes by plain integer arithmetic, clamped to the positive range
  function automatic exp_t model(smp_t s);
    exp_t e;
    int ax, ay;
    bit sw;
    ax = (s.x < 0) ? -int'(s.x) : int'(s.x);
    ay = (s.y < 0) ? -int'(s.y) : int'(s.y);
    if (ax > 32767) ax = 32767;
    if (ay > 32767) ay = 32767;
    sw     = (ay > ax);
    e.v    = s.v;
    e.xo   = W'(sw ? ay : ax);
    e.yo   = W'(sw ? ax : ay);
    e.q    = {s.y < 0, s.x < 0, sw};
    e.zero = (s.x == 0) && (s.y == 0);
    e.tag  = s.tag;
    return e;
  endfunction

  // Applies one clock of stimulus, updates the accepted-sample history and checks outputs
  task automatic step(input logic r, input logic en, input logic v,
                      input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                      input logic [TAG_W-1:0] t);
    smp_t s;
    exp_t e;
    rst = r; ena = en; valid_i = v; xi = x; yi = y; tag_i = t;
    @(posedge clk);
    #1;
    s.v = v; s.x = x; s.y = y; s.tag = t;
    if (r) hist.delete();
    else if (en) hist.push_back(s);
    if (hist.size() < 2) begin
      chk("rst_valid_o", valid_o, 0);
      chk("rst_xo", xo, 0);
      chk("rst_yo", yo, 0);
      chk("rst_q", q, 0);
      chk("rst_zero", zero, 0);
      chk("rst_tag_o", tag_o, 0);
    end else begin
      e = model(hist[hist.size()-2]);
      chk("valid_o", valid_o, e.v);
      if (e.v) begin
        chk("xo", xo, e.xo);
        chk("yo", yo, e.yo);
        chk("q", q, e.q);
        chk("zero", zero, e.zero);
        chk("tag_o", tag_o, e.tag);
        if (xo < yo) chk("xo_ge_yo", xo, yo);
      end
    end
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{x:  16'sd3,     y: -16'sd7,    tag: 4'd1, xo: 16'd7,     yo: 16'd3, q: 3'b101, zero: 1'b0};
    tbl[1] = '{x: -16'sd5,     y: -16'sd5,    tag: 4'd2, xo: 16'd5,     yo: 16'd5, q: 3'b110, zero: 1'b0};
    tbl[2] = '{x: -16'sd32768, y:  16'sd1,    tag: 4'd3, xo: 16'd32767, yo: 16'd1, q: 3'b010, zero: 1'b0};
    tbl[3] = '{x:  16'sd0,     y:  16'sd0,    tag: 4'd4, xo: 16'd0,     yo: 16'd0, q: 3'b000, zero: 1'b1};
    tbl[4] = '{x:  16'sd100,   y:  16'sd50,   tag: 4'd5, xo: 16'd100,   yo: 16'd50, q: 3'b000, zero: 1'b0};
    tbl[5] = '{x: -16'sd1,     y:  16'sd32767, tag: 4'd6, xo: 16'd32767, yo: 16'd1, q: 3'b011, zero: 1'b0};

    // Reset state
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Directed vectors: one sample then a bubble, output appears on the second edge
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, tbl[i].x, tbl[i].y, tbl[i].tag);
      chk("tbl_latency_valid", valid_o, (i == 0) ? 0 : 0);
      step(0, 1, 0, 0, 0, 0);
      chk("tbl_valid_o", valid_o, 1);
      chk("tbl_xo", xo, tbl[i].xo);
      chk("tbl_yo", yo, tbl[i].yo);
      chk("tbl_q", q, tbl[i].q);
      chk("tbl_zero", zero, tbl[i].zero);
      chk("tbl_tag", tag_o, tbl[i].tag);
      if (tbl[i].x == -16'sd32768) chk("nosat_xo", xo_u, 32'h8000);
      step(0, 1, 0, 0, 0, 0);
    end

    // Back-to-back tags 1..4 with a 3-cycle stall in the middle
    step(0, 1, 1, 16'sd10, -16'sd20, 4'd1);
    step(0, 1, 1, -16'sd30, 16'sd5, 4'd2);
    chk("stream_tag1", tag_o, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 16'sd999, 16'sd999, 4'd9);
      chk("stall_tag_hold", tag_o, 1);
      chk("stall_xo_hold", xo, 20);
      chk("stall_valid_hold", valid_o, 1);
    end
    step(0, 1, 1, -16'sd7, -16'sd8, 4'd3);
    chk("stream_tag2", tag_o, 2);
    step(0, 1, 1, 16'sd4, 16'sd4, 4'd4);
    chk("stream_tag3", tag_o, 3);
    step(0, 1, 0, 0, 0, 0);
    chk("stream_tag4", tag_o, 4);
    step(0, 1, 0, 0, 0, 0);
    chk("stream_drained", valid_o, 0);

    // Reset with two samples in flight while stalled
    step(0, 1, 1, 16'sd11, 16'sd22, 4'd7);
    step(0, 1, 1, 16'sd33, 16'sd44, 4'd8);
    step(1, 0, 0, 0, 0, 0);
    chk("inflight_rst_valid", valid_o, 0);
    step(0, 1, 1, -16'sd9, 16'sd2, 4'd5);
    chk("post_rst_one_edge", valid_o, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("post_rst_two_edges", valid_o, 1);
    chk("post_rst_tag", tag_o, 5);

    // Randomized sweep with stalls, bubbles and extreme values
    for (int i = 0; i < 400; i++) begin
      logic signed [W-1:0] rx, ry;
      rx = W'($urandom);
      ry = W'($urandom);
      if ($urandom_range(0, 9) == 0) rx = -16'sd32768;
      if ($urandom_range(0, 9) == 0) ry = -16'sd32768;
      if ($urandom_range(0, 15) == 0) begin rx = 0; ry = 0; end
      if ($urandom_range(0, 7) == 0) ry = rx;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 9) < 7), rx, ry, TAG_W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
